// File: rtl/vga_field_text_gen_if.sv
// Bus for vga_field_text_gen: pixel stream, snapshot controls, font ROM port and RGB output.
// The master side is the VGA sync/clock logic plus the font ROM; the slave side is the text generator.
interface vga_field_text_gen_if #(
  parameter int N_FIELDS = 3,
  parameter int SEL_W    = 3
);
  logic [9:0]            pixel_x;
  logic [8:0]            pixel_y;
  logic                  video_on;
  logic                  frame_start;
  logic [8*N_FIELDS-1:0] bcd_data;
  logic                  edit_en;
  logic [SEL_W-1:0]      edit_sel;
  logic [2:0]            bg_color;
  logic [10:0]           rom_addr;
  logic [7:0]            font_word;
  logic [2:0]            colors_out;
  logic                  pix_valid;

  modport master (
    output pixel_x, pixel_y, video_on, frame_start, bcd_data,
           edit_en, edit_sel, bg_color, font_word,
    input  rom_addr, colors_out, pix_valid
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, frame_start, bcd_data,
           edit_en, edit_sel, bg_color, font_word,
    output rom_addr, colors_out, pix_valid
  );
endinterface

// File: rtl/vga_field_text_gen.sv
// Pipelined two-digit BCD field text generator with per-frame snapshot and edit highlight.
// Optional blinking cursor is enabled by defining VGA_FIELD_BLINK_EN.
module vga_field_text_gen #(
  parameter int         N_FIELDS     = 3,
  parameter int         SCALE        = 1,
  parameter int         FIELD_COL0   = 16,
  parameter int         FIELD_ROW    = 4,
  parameter logic [6:0] SEP_CHAR     = 7'h3A,
  parameter int         BLINK_FRAMES = 30,
  parameter int         ROM_LAT      = 1,
  parameter int         SEL_W        = 3
) (
  input logic                  clk,
  input logic                  reset,
  vga_field_text_gen_if.slave  bus
);

  localparam int COL_SHIFT = 3 + SCALE;
  localparam int ROW_SHIFT = 4 + SCALE;

  logic [8*N_FIELDS-1:0] r_bcd;
  logic                  r_editEn;
  logic [SEL_W-1:0]      r_editSel;

  logic [9:0]  w_col;
  logic [8:0]  w_row;
  logic [3:0]  w_rowAddr;
  logic [2:0]  w_bitAddr;
  logic [6:0]  w_char;
  logic        w_inBox;
  logic        w_hlCell;
  logic        w_hlAct;
  logic        w_unused;

  logic [10:0] r_romAddr;
  logic        r_inBox1;
  logic        r_hl1;
  logic        r_von1;
  logic [2:0]  r_bit1;

  logic [ROM_LAT-1:0] r_inBoxD;
  logic [ROM_LAT-1:0] r_hlD;
  logic [ROM_LAT-1:0] r_vonD;
  logic [2:0]         r_bitD [ROM_LAT];

  logic        w_font;
  logic [2:0]  w_color;
  logic [2:0]  r_colors;
  logic        r_pixValid;

  function automatic logic [6:0] digitChar(input logic [3:0] n);
    return (n <= 4'd9) ? (7'h30 + {3'b000, n}) : 7'h20;
  endfunction

  // Controls are captured only at frame_start so the visible frame never tears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcd     <= '0;
      r_editEn  <= 1'b0;
      r_editSel <= '0;
    end else if (bus.frame_start) begin
      r_bcd     <= bus.bcd_data;
      r_editEn  <= bus.edit_en;
      r_editSel <= bus.edit_sel;
    end
  end

`ifdef VGA_FIELD_BLINK_EN
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] r_frameCnt;
  logic             r_phase;
  logic             w_editChg;

  assign w_editChg = (bus.edit_en != r_editEn) || (bus.edit_sel != r_editSel);

  // A new edit target restarts the blink with the cursor visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frameCnt <= '0;
      r_phase    <= 1'b1;
    end else if (bus.frame_start) begin
      if (w_editChg) begin
        r_frameCnt <= '0;
        r_phase    <= 1'b1;
      end else if (r_frameCnt == CNT_W'(BLINK_FRAMES - 1)) begin
        r_frameCnt <= '0;
        r_phase    <= ~r_phase;
      end else begin
        r_frameCnt <= r_frameCnt + 1'b1;
      end
    end
  end

  assign w_hlAct = w_hlCell & r_phase;
`else
  assign w_hlAct = w_hlCell;
`endif

  assign w_col     = bus.pixel_x >> COL_SHIFT;
  assign w_row     = bus.pixel_y >> ROW_SHIFT;
  assign w_rowAddr = bus.pixel_y[SCALE+3:SCALE];
  assign w_bitAddr = bus.pixel_x[SCALE+2:SCALE];
  assign w_unused  = ^{bus.pixel_x, bus.pixel_y};

  always_comb begin
    w_char   = 7'h20;
    w_inBox  = 1'b0;
    w_hlCell = 1'b0;
    if (int'(w_row) == FIELD_ROW) begin
      if ((int'(w_col) >= FIELD_COL0 - 1) && (int'(w_col) <= FIELD_COL0 + 3*N_FIELDS - 1))
        w_inBox = 1'b1;
      for (int k = 0; k < N_FIELDS; k++) begin
        if (int'(w_col) == FIELD_COL0 + 3*k) begin
          w_char   = digitChar(r_bcd[8*(N_FIELDS-k)-1 -: 4]);
          w_hlCell = r_editEn && (int'(r_editSel) == k);
        end else if (int'(w_col) == FIELD_COL0 + 3*k + 1) begin
          w_char   = digitChar(r_bcd[8*(N_FIELDS-k)-5 -: 4]);
          w_hlCell = r_editEn && (int'(r_editSel) == k);
        end else if ((int'(w_col) == FIELD_COL0 + 3*k + 2) && (k < N_FIELDS - 1)) begin
          w_char   = SEP_CHAR;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_romAddr <= '0;
      r_inBox1  <= 1'b0;
      r_hl1     <= 1'b0;
      r_von1    <= 1'b0;
      r_bit1    <= '0;
    end else begin
      r_romAddr <= {w_char, w_rowAddr};
      r_inBox1  <= w_inBox;
      r_hl1     <= w_hlAct;
      r_von1    <= bus.video_on;
      r_bit1    <= w_bitAddr;
    end
  end

  assign bus.rom_addr = r_romAddr;

  // Cell attributes ride alongside the ROM read so they meet font_word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inBoxD <= '0;
      r_hlD    <= '0;
      r_vonD   <= '0;
      for (int i = 0; i < ROM_LAT; i++) r_bitD[i] <= '0;
    end else begin
      r_inBoxD[0] <= r_inBox1;
      r_hlD[0]    <= r_hl1;
      r_vonD[0]   <= r_von1;
      r_bitD[0]   <= r_bit1;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_inBoxD[i] <= r_inBoxD[i-1];
        r_hlD[i]    <= r_hlD[i-1];
        r_vonD[i]   <= r_vonD[i-1];
        r_bitD[i]   <= r_bitD[i-1];
      end
    end
  end

  assign w_font = bus.font_word[3'd7 - r_bitD[ROM_LAT-1]];

  // Highlighted digits render as white-on-black, box text as black-on-background.
  always_comb begin
    w_color = 3'b000;
    if (r_vonD[ROM_LAT-1]) begin
      if (r_hlD[ROM_LAT-1])
        w_color = w_font ? 3'b111 : 3'b000;
      else if (r_inBoxD[ROM_LAT-1])
        w_color = w_font ? 3'b000 : bus.bg_color;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_colors   <= '0;
      r_pixValid <= 1'b0;
    end else begin
      r_colors   <= w_color;
      r_pixValid <= r_vonD[ROM_LAT-1];
    end
  end

  assign bus.colors_out = r_colors;
  assign bus.pix_valid  = r_pixValid;

endmodule

// File: tb/tb_vga_field_text_gen.sv
// Self-checking bench for vga_field_text_gen: layout, snapshot, colours, reset, and the
// blink sequence when VGA_FIELD_BLINK_EN is defined.
module tb_vga_field_text_gen;
  localparam int NF   = 3;
  localparam int SC   = 1;
  localparam int COL0 = 16;
  localparam int FROW = 4;
  localparam int BF   = 2;
  localparam int LAT  = 1;
  localparam int SW   = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_field_text_gen_if #(.N_FIELDS(NF), .SEL_W(SW)) bus ();

  vga_field_text_gen #(
    .N_FIELDS(NF), .SCALE(SC), .FIELD_COL0(COL0), .FIELD_ROW(FROW),
    .SEP_CHAR(7'h3A), .BLINK_FRAMES(BF), .ROM_LAT(LAT), .SEL_W(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int fontMode = 0;
  logic [2:0] bgVal = 3'b000;

  function automatic logic [7:0] fontFn(input logic [10:0] a);
    logic [7:0] f;
    case (fontMode)
      0:       f = 8'hFF;
      1:       f = 8'h00;
      default: f = 8'hA5 ^ a[7:0];
    endcase
    return f;
  endfunction

  // Font ROM with LAT clocks of read latency.
  logic [7:0] romPipe [LAT];
  always @(posedge clk) begin
    romPipe[0] <= fontFn(bus.rom_addr);
    for (int i = 1; i < LAT; i++) romPipe[i] <= romPipe[i-1];
  end
  assign bus.font_word = romPipe[LAT-1];

  // Model of the snapshot and blink state.
  logic [8*NF-1:0] mBcd;
  logic            mEn;
  logic [SW-1:0]   mSel;
  int              mCnt;
  logic            mPhase;

  function automatic logic [6:0] mDigit(input logic [3:0] n);
    return (n < 4'd10) ? (7'h30 | {3'b000, n}) : 7'h20;
  endfunction

  function automatic logic [10:0] mRom(input int x, input int y);
    int col, row, c, k;
    logic [7:0] fb;
    logic [6:0] ch;
    logic [3:0] ra;
    col = x / (8 << SC);
    row = y / (16 << SC);
    c   = col - COL0;
    ra  = 4'((y >> SC) % 16);
    ch  = 7'h20;
    if (row == FROW && c >= 0 && c < 3*NF) begin
      k  = c / 3;
      fb = mBcd[8*(NF-1-k) +: 8];
      case (c % 3)
        0:       ch = mDigit(fb[7:4]);
        1:       ch = mDigit(fb[3:0]);
        default: if (k < NF-1) ch = 7'h3A;
      endcase
    end
    return {ch, ra};
  endfunction

  function automatic logic [2:0] mColor(input int x, input int y, input logic von);
    int col, row, c, b;
    logic [10:0] a;
    logic [7:0]  f;
    logic        fbit, inBox, hl;
    col   = x / (8 << SC);
    row   = y / (16 << SC);
    c     = col - COL0;
    b     = (x >> SC) % 8;
    a     = mRom(x, y);
    f     = fontFn(a);
    fbit  = f[7-b];
    inBox = (row == FROW) && (c >= -1) && (c <= 3*NF-1);
    hl    = mEn && (int'(mSel) < NF) && (row == FROW) && (c >= 0) && (c < 3*NF)
            && (c % 3 != 2) && (c / 3 == int'(mSel));
`ifdef VGA_FIELD_BLINK_EN
    hl = hl && mPhase;
`endif
    if (!von) return 3'b000;
    if (hl) return fbit ? 3'b111 : 3'b000;
    if (inBox) return fbit ? 3'b000 : bgVal;
    return 3'b000;
  endfunction

  typedef struct { int due; logic [10:0] rom; string name; } romExp_t;
  typedef struct { int due; logic [2:0] col; logic pv; string name; } colExp_t;
  romExp_t romQ[$];
  colExp_t colQ[$];

  int cyc  = 0;
  int nVec = 0;
  int nMis = 0;

  task automatic checkOutput(input string name, input logic [10:0] act, input logic [10:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    romExp_t r;
    colExp_t c;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (romQ.size() > 0 && romQ[0].due <= cyc) begin
      r = romQ.pop_front();
      checkOutput({r.name, " rom"}, bus.rom_addr, r.rom);
    end
    while (colQ.size() > 0 && colQ[0].due <= cyc) begin
      c = colQ.pop_front();
      checkOutput({c.name, " rgb"}, 11'(bus.colors_out), 11'(c.col));
      checkOutput({c.name, " pv"}, 11'(bus.pix_valid), 11'(c.pv));
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input logic von, input string name,
                               input logic [10:0] romExp, input logic [2:0] colExp);
    bus.pixel_x  = 10'(x);
    bus.pixel_y  = 9'(y);
    bus.video_on = von;
    romQ.push_back('{due: cyc + 1, rom: romExp, name: name});
    colQ.push_back('{due: cyc + LAT + 2, col: colExp, pv: von, name: name});
    tick();
  endtask

  task automatic drain();
    bus.video_on = 1'b0;
    repeat (LAT + 2) tick();
  endtask

  task automatic pulseFrame(input logic [8*NF-1:0] bcd, input logic en, input logic [SW-1:0] sel);
    bus.bcd_data    = bcd;
    bus.edit_en     = en;
    bus.edit_sel    = sel;
    bus.video_on    = 1'b0;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
`ifdef VGA_FIELD_BLINK_EN
    if (en != mEn || sel != mSel) begin
      mCnt = 0; mPhase = 1'b1;
    end else if (mCnt == BF - 1) begin
      mCnt = 0; mPhase = ~mPhase;
    end else begin
      mCnt++;
    end
`endif
    mBcd = bcd; mEn = en; mSel = sel;
  endtask

  task automatic resetModel();
    mBcd = '0; mEn = 1'b0; mSel = '0; mCnt = 0; mPhase = 1'b1;
  endtask

  typedef struct { int x; int y; logic [10:0] rom; string name; } layVec_t;
  typedef struct { int mode; int x; int y; logic von; logic [2:0] col; string name; } colVec_t;
  layVec_t lay [13];
  colVec_t cv  [11];
  logic [2:0] blinkExp [10];
  int bx;
  logic [2:0] bexp;

  initial begin
    lay[0]  = '{256, 128, 11'h310, "c16 tens"};
    lay[1]  = '{272, 128, 11'h320, "c17 units"};
    lay[2]  = '{288, 128, 11'h3A0, "c18 sep"};
    lay[3]  = '{304, 128, 11'h330, "c19 f1 tens"};
    lay[4]  = '{320, 128, 11'h340, "c20 f1 units"};
    lay[5]  = '{352, 128, 11'h350, "c22 f2 tens"};
    lay[6]  = '{368, 128, 11'h360, "c23 f2 units"};
    lay[7]  = '{384, 128, 11'h200, "c24 no trailing sep"};
    lay[8]  = '{255, 128, 11'h200, "c15 before fields"};
    lay[9]  = '{256,  96, 11'h200, "row3"};
    lay[10] = '{271, 159, 11'h31F, "c16 last line"};
    lay[11] = '{256, 160, 11'h200, "row5"};
    lay[12] = '{344, 138, 11'h3A5, "c21 sep line5"};

    cv[0]  = '{0, 304, 128, 1'b1, 3'b111, "hl c19 font1"};
    cv[1]  = '{0, 256, 128, 1'b1, 3'b000, "box c16 font1"};
    cv[2]  = '{1, 256, 128, 1'b1, 3'b010, "box c16 font0"};
    cv[3]  = '{0, 304, 128, 1'b0, 3'b000, "video off"};
    cv[4]  = '{1, 304, 128, 1'b1, 3'b000, "hl c19 font0"};
    cv[5]  = '{0, 320, 128, 1'b1, 3'b111, "hl c20 font1"};
    cv[6]  = '{1, 336, 128, 1'b1, 3'b010, "sep c21 font0"};
    cv[7]  = '{1, 240, 128, 1'b1, 3'b010, "box left edge"};
    cv[8]  = '{1, 384, 128, 1'b1, 3'b010, "box right edge"};
    cv[9]  = '{1, 400, 128, 1'b1, 3'b000, "past box"};
    cv[10] = '{1, 256,  96, 1'b1, 3'b000, "row above box"};

    blinkExp = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b111, 3'b111, 3'b000,
                 3'b111, 3'b111, 3'b000};

    bus.pixel_x = '0; bus.pixel_y = '0; bus.video_on = 1'b0; bus.frame_start = 1'b0;
    bus.bcd_data = '0; bus.edit_en = 1'b0; bus.edit_sel = '0; bus.bg_color = bgVal;
    resetModel();

    repeat (3) tick();
    checkOutput("reset rom", bus.rom_addr, 11'h000);
    checkOutput("reset rgb", 11'(bus.colors_out), 11'h000);
    checkOutput("reset pv", 11'(bus.pix_valid), 11'h000);
    reset = 1'b1;
    tick();

    applyStimulus(256, 128, 1'b1, "zero digit after reset", 11'h300, mColor(256, 128, 1'b1));
    drain();

    pulseFrame(24'h123456, 1'b0, 3'd0);
    bgVal = 3'b101; bus.bg_color = bgVal; fontMode = 2;
    for (int i = 0; i < 13; i++)
      applyStimulus(lay[i].x, lay[i].y, 1'b1, lay[i].name, lay[i].rom,
                    mColor(lay[i].x, lay[i].y, 1'b1));
    drain();

    bus.bcd_data = 24'h999999;
    applyStimulus(256, 128, 1'b1, "no tear", 11'h310, mColor(256, 128, 1'b1));
    drain();
    pulseFrame(24'h999999, 1'b0, 3'd0);
    applyStimulus(256, 128, 1'b1, "after frame 999999", 11'h390, mColor(256, 128, 1'b1));
    drain();
    pulseFrame(24'hA00000, 1'b0, 3'd0);
    applyStimulus(256, 128, 1'b1, "invalid bcd tens", 11'h200, mColor(256, 128, 1'b1));
    applyStimulus(272, 128, 1'b1, "zero units", 11'h300, mColor(272, 128, 1'b1));
    drain();

    pulseFrame(24'h123456, 1'b1, 3'd1);
    bgVal = 3'b010; bus.bg_color = bgVal;
    for (int i = 0; i < 11; i++) begin
      fontMode = cv[i].mode;
      applyStimulus(cv[i].x, cv[i].y, cv[i].von, cv[i].name, mRom(cv[i].x, cv[i].y), cv[i].col);
      drain();
    end

    pulseFrame(24'h123456, 1'b1, 3'd5);
    fontMode = 0;
    for (int c = 15; c <= 25; c++)
      applyStimulus(c * 16, 128, 1'b1, $sformatf("sel5 c%0d", c), mRom(c * 16, 128), 3'b000);
    drain();

    pulseFrame(24'h123456, 1'b0, 3'd0);
    for (int i = 0; i < 10; i++) begin
      pulseFrame(24'h123456, 1'b1, (i < 7) ? 3'd0 : 3'd1);
      fontMode = 0;
      bx = (i < 7) ? 256 : 304;
`ifdef VGA_FIELD_BLINK_EN
      bexp = blinkExp[i];
`else
      bexp = 3'b111;
`endif
      applyStimulus(bx, 128, 1'b1, $sformatf("blink pulse %0d", i), mRom(bx, 128), bexp);
      drain();
    end

    pulseFrame(24'h123456, 1'b0, 3'd0);
    bgVal = 3'b010; bus.bg_color = bgVal; fontMode = 1;
    applyStimulus(256, 128, 1'b1, "pre-reset", 11'h310, 3'b010);
    repeat (LAT + 1) tick();
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset rgb", 11'(bus.colors_out), 11'h000);
    checkOutput("async reset pv", 11'(bus.pix_valid), 11'h000);
    checkOutput("async reset rom", bus.rom_addr, 11'h000);
    romQ.delete();
    colQ.delete();
    tick();
    reset = 1'b1;
    resetModel();
    applyStimulus(256, 128, 1'b1, "post-reset zero", 11'h300, mColor(256, 128, 1'b1));
    drain();
    pulseFrame(24'h123456, 1'b0, 3'd0);
    applyStimulus(256, 128, 1'b1, "post-reset frame", 11'h310, mColor(256, 128, 1'b1));
    drain();

    checkOutput("scoreboard empty", 11'(romQ.size() + colQ.size()), 11'h000);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
